// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave bridging transfers onto a single-port synchronous SRAM
module ahb_sram_slave #(
  parameter int          AW        = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hsel,
  input  logic [31:0]   haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [31:0]   hwdata,
  output logic [31:0]   hrdata,
  output logic          hreadyout,
  output logic          hresp,
  output logic          sram_csb,
  output logic          sram_web,
  output logic [3:0]    sram_wmask,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_din,
  input  logic [31:0]   sram_dout
);
  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, ERR1, ERR2} state_t;
  state_t        r_state, w_next;
  logic [AW+1:0] r_addr;
  logic [2:0]    r_size;
  logic          w_ready, w_accept, w_err, w_wr, w_rd;
  logic [3:0]    w_mask;
  assign w_ready  = r_state inside {IDLE, WR, RD2, ERR2};
  assign w_accept = w_ready && hsel && htrans[1];
  assign w_err    = (hsize > 3'd2) || (hsize == 3'd1 && haddr[0]) ||
                    (hsize == 3'd2 && haddr[1:0] != 2'b00) ||
                    (haddr[31:AW+2] != BASE_ADDR[31:AW+2]);
  always_comb begin
    w_next = r_state;
    if (w_ready) w_next = !w_accept ? IDLE : w_err ? ERR1 : hwrite ? WR : RD1;
    else         w_next = (r_state == RD1) ? RD2 : ERR2;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_size  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= haddr[AW+1:0];
        r_size <= hsize;
      end
    end
  end
  // SRAM strobes are gated by reset so a write caught by reset never reaches the macro
  assign w_wr   = rst_n && (r_state == WR);
  assign w_rd   = rst_n && (r_state == RD1);
  assign w_mask = (r_size == 3'd0) ? (4'b0001 << r_addr[1:0]) :
                  (r_size == 3'd1) ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign hreadyout  = w_ready;
  assign hresp      = r_state inside {ERR1, ERR2};
  assign hrdata     = (r_state == RD2) ? sram_dout : '0;
  assign sram_csb   = !(w_wr || w_rd);
  assign sram_web   = !w_wr;
  assign sram_wmask = w_wr ? w_mask : 4'b0000;
  assign sram_addr  = r_addr[AW+1:2];
  assign sram_din   = hwdata;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: randomized scoreboard bench with a byte-array reference memory
module tb_ahb_sram_slave;
  logic        clk = 0, rst_n = 0, hsel = 0, hwrite = 0, clr = 1;
  logic [31:0] haddr = 0, hwdata = 0, hrdata, sram_din, sram_dout = 0;
  logic [1:0]  htrans = 0;
  logic [2:0]  hsize = 0;
  logic        hreadyout, hresp, sram_csb, sram_web;
  logic [3:0]  sram_wmask;
  logic [9:0]  sram_addr;

  ahb_sram_slave #(.AW(10), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
    .hreadyout(hreadyout), .hresp(hresp), .sram_csb(sram_csb), .sram_web(sram_web),
    .sram_wmask(sram_wmask), .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout));

  always #5 clk = ~clk;

  // SRAM macro: one-cycle read latency, per-byte write mask
  logic [31:0] sram_mem [0:1023];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= '0;
    end else if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else sram_dout <= sram_mem[sram_addr];
    end
  end

  typedef struct {bit rd; bit err; logic [31:0] data;} exp_t;
  typedef struct {logic [9:0] addr; logic [3:0] mask; logic [31:0] din;} wexp_t;
  exp_t  exp_q[$];
  wexp_t wq[$];
  bit [7:0] ref_mem [0:4095];
  int checks = 0, errors = 0;
  bit pend = 0;
  logic [31:0] pend_wd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applied in acceptance order, so a read sees every earlier write
  task automatic model(input logic [31:0] a, input logic wr, input logic [2:0] sz, input logic [31:0] wd);
    exp_t e;
    wexp_t w;
    int n;
    int unsigned base;
    e.rd = !wr; e.err = 0; e.data = 0;
    if (sz > 2 || (a % (1 << sz)) != 0 || a >= 32'h1000) begin
      e.err = 1;
    end else if (wr) begin
      n = 1 << sz;
      w.addr = a[11:2]; w.mask = 0; w.din = wd;
      for (int i = 0; i < n; i++) begin
        ref_mem[(a + i) % 4096] = wd[8*((a + i) % 4) +: 8];
        w.mask[(a + i) % 4] = 1'b1;
      end
      wq.push_back(w);
    end else begin
      base = a & ~32'h3;
      e.data = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    end
    exp_q.push_back(e);
  endtask

  task automatic xfer(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic wr, input logic [2:0] sz, input logic [31:0] wd);
    int n = 0;
    hwdata = pend_wd;
    hsel = sel; htrans = tr; haddr = a; hwrite = wr; hsize = sz;
    @(negedge clk);
    while (!hreadyout) begin
      if (++n > 8) begin
        checks++; errors++;
        $display("FAIL hready_timeout act=0 exp=1 t=%0t", $time);
        break;
      end
      @(negedge clk);
    end
    if (hreadyout && sel && tr[1]) model(a, wr, sz, wd);
    pend_wd = wd;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    xfer(0, 2'b00, 0, 0, 0, $urandom);
  endtask

  task automatic chk_reset_state();
    @(negedge clk);
    chk("rst_hready", {31'b0, hreadyout}, 1);
    chk("rst_hresp", {31'b0, hresp}, 0);
    chk("rst_csb", {31'b0, sram_csb}, 1);
    chk("rst_web", {31'b0, sram_web}, 1);
    chk("rst_wmask", {28'b0, sram_wmask}, 0);
    chk("rst_hrdata", hrdata, 0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops expected responses as data phases complete
  always @(negedge clk) begin
    exp_t e;
    wexp_t w;
    if (!rst_n) begin
      pend = 0;
      exp_q.delete();
      wq.delete();
    end else begin
      if (!sram_csb && !sram_web) begin
        if (wq.size() == 0) chk("unexpected_write", {31'b0, sram_web}, 1);
        else begin
          w = wq.pop_front();
          chk("wr_addr", {22'b0, sram_addr}, {22'b0, w.addr});
          chk("wr_mask", {28'b0, sram_wmask}, {28'b0, w.mask});
          chk("wr_din", sram_din, w.din);
        end
      end
      if (pend) begin
        if (exp_q.size() == 0) chk("exp_q_empty", 0, 1);
        else if (!hreadyout) begin
          chk("wait_hresp", {31'b0, hresp}, {31'b0, exp_q[0].err});
          if (exp_q[0].err) chk("err1_csb", {31'b0, sram_csb}, 1);
        end else begin
          e = exp_q.pop_front();
          chk("hresp", {31'b0, hresp}, {31'b0, e.err});
          if (e.err) chk("err2_csb", {31'b0, sram_csb}, 1);
          chk(e.rd && !e.err ? "hrdata" : "hrdata_zero", hrdata, e.data);
        end
      end
      pend = (hreadyout && hsel && htrans[1]) || (pend && !hreadyout);
    end
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    repeat (2) @(posedge clk);
    #1 rst_n = 1; clr = 0;
    chk_reset_state();
    xfer(1, 2'b10, 32'h100, 1, 2, 32'hDEADBEEF);
    xfer(1, 2'b10, 32'h100, 0, 2, 0);
    idle();
    xfer(1, 2'b10, 32'h103, 1, 0, 32'hAA000000);
    xfer(1, 2'b10, 32'h100, 0, 2, 0);
    idle();
    xfer(1, 2'b10, 32'h200, 1, 2, 32'h12345678);
    xfer(1, 2'b11, 32'h200, 0, 2, 0);
    idle();
    xfer(1, 2'b10, 32'h102, 0, 2, 0);
    idle();
    xfer(1, 2'b10, 32'h1000, 0, 2, 0);
    xfer(1, 2'b10, 32'h0, 0, 2, 0);
    xfer(1, 2'b10, 32'h104, 1, 3, 32'h1);
    xfer(1, 2'b10, 32'h101, 1, 1, 32'h2);
    xfer(0, 2'b10, 32'h100, 1, 2, 32'h3);
    xfer(1, 2'b01, 32'h100, 1, 2, 32'h4);
    xfer(1, 2'b10, 32'h106, 1, 1, 32'hBEEF5555);
    xfer(1, 2'b10, 32'h104, 0, 2, 0);
    idle();
    // reset while the read sits in RD1
    xfer(1, 2'b10, 32'h100, 0, 2, 0);
    hsel = 0; htrans = 0; rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    chk_reset_state();
    xfer(1, 2'b10, 32'h100, 0, 2, 0);
    idle();
    for (int i = 0; i < 400; i++) begin
      a  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 32'h1FFF) : $urandom_range(0, 63);
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if (sz <= 2 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 1);
      xfer($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), a, 1'($urandom_range(0, 1)), sz, $urandom);
    end
    repeat (3) idle();
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_wr", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
